p2_frame_decoder: RTL

//  Receive-side parser for the player-to-player UART link. Pops bytes from the UART RX FIFO,

---
 rtl/p2_frame_decoder_if.sv | 26 ++
 rtl/p2_frame_decoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/p2_frame_decoder_if.sv
// FIFO-side and game-side signals of the player-2 frame decoder.
// The master side is the environment (RX FIFO plus game logic); the slave side is the decoder.
interface p2_frame_decoder_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic [7:0] p2_speed;
  logic [7:0] p2_position;
  logic [7:0] p2_flags;
  logic       frame_valid;
  logic       frame_err;
  logic       link_up;
  logic [7:0] err_count;

  modport master (
    output rx_empty, r_data,
    input  rd_uart, p2_speed, p2_position, p2_flags,
    input  frame_valid, frame_err, link_up, err_count
  );

  modport slave (
    input  rx_empty, r_data,
    output rd_uart, p2_speed, p2_position, p2_flags,
    output frame_valid, frame_err, link_up, err_count
  );
endinterface

// File: rtl/p2_frame_decoder.sv
// Receive-side parser for the player-to-player UART link: [SYNC][speed][pos][flags][xor].
// Publishes validated fields with a one-cycle strobe and tracks link health.
module p2_frame_decoder #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [15:0] BYTE_TIMEOUT = 16'd50000,
  parameter logic [23:0] LINK_TIMEOUT = 24'd6500000
) (
  input logic               clk,
  input logic               rst,
  p2_frame_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t      r_state, w_state_nx;
  logic [1:0]  r_idx, w_idx_nx;
  logic [7:0]  r_chk, w_chk_nx;
  logic [7:0]  r_sh_spd, r_sh_pos, r_sh_flg;
  logic [7:0]  r_spd, r_pos, r_flg, r_err_cnt;
  logic        r_rd, r_fv, r_fe, r_link;
  logic [15:0] r_btmr;
  logic [23:0] r_ltmr;
  logic        w_take, w_to, w_good, w_bad, w_pl_wr;

  // A pop is always followed by one idle cycle so the FWFT head has time to advance.
  assign w_take = !bus.rx_empty && !r_rd;
  // Fires on the cycle the byte timer would step onto BYTE_TIMEOUT.
  assign w_to   = (r_state != S_HUNT) && (r_btmr == BYTE_TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HUNT;
      r_idx   <= 2'd0;
      r_chk   <= 8'h00;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_chk   <= w_chk_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_chk_nx   = r_chk;
    w_pl_wr    = 1'b0;
    w_good     = 1'b0;
    w_bad      = 1'b0;
    if (w_to) begin
      // Timeout aborts the frame; a byte arriving now is parsed as if already in HUNT.
      w_bad      = 1'b1;
      w_state_nx = S_HUNT;
      if (w_take && bus.r_data == SYNC_BYTE) begin
        w_state_nx = S_PAYLOAD;
        w_idx_nx   = 2'd0;
        w_chk_nx   = SYNC_BYTE;
      end
    end else if (w_take) begin
      case (r_state)
        S_HUNT: begin
          if (bus.r_data == SYNC_BYTE) begin
            w_state_nx = S_PAYLOAD;
            w_idx_nx   = 2'd0;
            w_chk_nx   = SYNC_BYTE;
          end
        end
        S_PAYLOAD: begin
          w_pl_wr  = 1'b1;
          w_chk_nx = r_chk ^ bus.r_data;
          if (r_idx == 2'd2) w_state_nx = S_CHECK;
          else               w_idx_nx   = r_idx + 2'd1;
        end
        S_CHECK: begin
          w_state_nx = S_HUNT;
          if (bus.r_data == r_chk) w_good = 1'b1;
          else                     w_bad  = 1'b1;
        end
        default: w_state_nx = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd      <= 1'b0;
      r_fv      <= 1'b0;
      r_fe      <= 1'b0;
      r_link    <= 1'b0;
      r_sh_spd  <= 8'h00;
      r_sh_pos  <= 8'h00;
      r_sh_flg  <= 8'h00;
      r_spd     <= 8'h00;
      r_pos     <= 8'h00;
      r_flg     <= 8'h00;
      r_err_cnt <= 8'h00;
      r_btmr    <= 16'd0;
      r_ltmr    <= 24'd0;
    end else begin
      r_rd <= w_take;
      r_fv <= w_good;
      r_fe <= w_bad;

      if (w_pl_wr) begin
        case (r_idx)
          2'd0:    r_sh_spd <= bus.r_data;
          2'd1:    r_sh_pos <= bus.r_data;
          default: r_sh_flg <= bus.r_data;
        endcase
      end

      if (w_good) begin
        r_spd <= r_sh_spd;
        r_pos <= r_sh_pos;
        r_flg <= r_sh_flg;
      end

      if (w_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;

      if (w_take || w_to || r_state == S_HUNT) r_btmr <= 16'd0;
      else                                     r_btmr <= r_btmr + 16'd1;

      // A fresh good frame beats a link timeout landing in the same cycle.
      if (w_good) begin
        r_ltmr <= 24'd0;
        r_link <= 1'b1;
      end else begin
        if (r_ltmr != LINK_TIMEOUT)           r_ltmr <= r_ltmr + 24'd1;
        if (r_ltmr >= LINK_TIMEOUT - 24'd1)   r_link <= 1'b0;
      end
    end
  end

  assign bus.rd_uart     = r_rd;
  assign bus.p2_speed    = r_spd;
  assign bus.p2_position = r_pos;
  assign bus.p2_flags    = r_flg;
  assign bus.frame_valid = r_fv;
  assign bus.frame_err   = r_fe;
  assign bus.link_up     = r_link;
  assign bus.err_count   = r_err_cnt;

endmodule
